// File: rtl/alu_secure_mc.sv
`default_nettype none
// ============================================================================
// Module : alu_secure_mc
// Multi-cycle WIDTH-bit ALU with valid/ready handshakes, iterative shifts and
// a shift-add multiplier. All outputs are registered and cycle-deterministic.
// Rev    : 1.0
// ============================================================================
module alu_secure_mc #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;
  localparam logic [2:0] c_op_shl = 3'b101;
  localparam logic [2:0] c_op_shr = 3'b110;
  localparam logic [2:0] c_op_mul = 3'b111;

  localparam logic [SHW:0] c_cnt_one = (SHW+1)'(1);
  localparam logic [SHW:0] c_cnt_mul = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_accept;
  logic               w_last;
  logic [SHW-1:0]     w_ld_shamt;
  logic [SHW:0]       w_ld_cnt;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_shl;
  logic [WIDTH-1:0]   w_shr;
  logic [WIDTH:0]     w_mac;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == c_cnt_one);

  // Iteration count: shifts take one cycle per bit (minimum one), MUL one per multiplier bit.
  always_comb begin
    w_ld_shamt = B[SHW-1:0];
    w_ld_cnt   = c_cnt_one;
    if (op == c_op_mul) begin
      w_ld_cnt = c_cnt_mul;
    end else if ((op == c_op_shl || op == c_op_shr) && (w_ld_shamt != '0)) begin
      w_ld_cnt = {1'b0, w_ld_shamt};
    end
  end

  always_comb begin
    w_shamt     = r_b[SHW-1:0];
    w_sum       = {1'b0, r_a} + {1'b0, r_b};
    w_diff      = r_a - r_b;
    w_shl       = {r_a[WIDTH-2:0], 1'b0};
    w_shr       = {1'b0, r_a[WIDTH-1:1]};
    // Low half of r_prod holds the remaining multiplier bits; high half accumulates.
    w_mac       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_prod[0]}} & {1'b0, r_a});
    w_prod_next = {w_mac, r_prod[WIDTH-1:1]};
    w_res       = '0;
    w_c         = 1'b0;
    w_v         = 1'b0;
    case (r_op)
      c_op_add: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = w_diff;
        w_c   = (r_a < r_b);
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      c_op_and: w_res = r_a & r_b;
      c_op_or:  w_res = r_a | r_b;
      c_op_xor: w_res = r_a ^ r_b;
      c_op_shl: begin
        if (w_shamt == '0) begin
          w_res = r_a;
        end else begin
          w_res = w_shl;
          w_c   = r_a[WIDTH-1];
        end
      end
      c_op_shr: begin
        if (w_shamt == '0) begin
          w_res = r_a;
        end else begin
          w_res = w_shr;
          w_c   = r_a[0];
        end
      end
      c_op_mul: begin
        w_res = w_prod_next[WIDTH-1:0];
        w_v   = |w_prod_next[2*WIDTH-1:WIDTH];
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = EXEC;
      end
      EXEC: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_prod   <= '0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= A;
            r_b    <= B;
            r_op   <= op;
            r_cnt  <= w_ld_cnt;
            r_prod <= {{WIDTH{1'b0}}, B};
          end
        end
        EXEC: begin
          r_cnt <= r_cnt - c_cnt_one;
          if (r_op == c_op_shl && w_shamt != '0) r_a <= w_shl;
          if (r_op == c_op_shr && w_shamt != '0) r_a <= w_shr;
          if (r_op == c_op_mul) r_prod <= w_prod_next;
          if (w_last) begin
            result   <= w_res;
            carry    <= w_c;
            overflow <= w_v;
            zero     <= (w_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_secure_mc.md
# alu_secure_mc

Parametrised, multi-cycle successor to the 4-bit secure ALU: a WIDTH-bit arithmetic/logic unit with eight operations, a valid/ready handshake on both input and output, and an internal FSM that executes iterative shifts and a shift-add multiply over several cycles. It sits in the same lockstep clean-vs-trojan evaluation flow as the existing ALU, so every output is registered and fully deterministic cycle by cycle.

## Interface
- WIDTH, 4, operand/result width; power of two, >= 4
- SHW, $clog2(WIDTH), derived, shift-amount width (not overridable)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- A  input  WIDTH  operand A, sampled on input handshake
- B  input  WIDTH  operand B, sampled on input handshake
- op  input  3  opcode, sampled on input handshake
- in_valid  input  1  operands/op valid
- in_ready  output  1  high exactly when FSM is IDLE
- result  output  WIDTH  registered result
- carry  output  1  registered carry/borrow/shift-out flag
- zero  output  1  registered, result == 0
- overflow  output  1  registered signed/multiply overflow flag
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result

## Operation
- FSM state register `state`: IDLE, EXEC, DONE.
- IDLE: in_ready=1. On in_valid && in_ready at an edge: latch A, B, op into internal registers, load iteration counter, go EXEC. Inputs are ignored at all other times.
- EXEC: one step per cycle; counter decrements; on last step write result/flags, go DONE.
- DONE: out_valid=1; result/flags held stable. On out_valid && out_ready at an edge: out_valid drops, go IDLE. result/flags keep last value until overwritten.
- Opcodes and EXEC length L:
  - 000 ADD, L=1: result=A+B mod 2^WIDTH; carry=carry-out; overflow=signed overflow.
  - 001 SUB, L=1: result=A-B mod 2^WIDTH; carry=1 iff A<B unsigned (borrow); overflow=signed overflow.
  - 010 AND / 011 OR / 100 XOR, L=1: bitwise; carry=0, overflow=0.
  - 101 SHL, L=max(1,s) with s=B[SHW-1:0]: one-bit logical left shift per cycle; carry=last bit shifted out (0 if s=0); overflow=0.
  - 110 SHR, L=max(1,s): one-bit logical right shift per cycle; carry=last bit shifted out (0 if s=0); overflow=0.
  - 111 MUL, L=WIDTH: unsigned shift-add over 2*WIDTH-bit accumulator; result=low WIDTH bits; overflow=1 iff high WIDTH bits nonzero; carry=0.
- Upper bits of B above SHW ignored for shifts.
- zero always computed from the final result written.

## Timing
- Reset (rst_n low, async): state=IDLE, result=0, carry=0, zero=0, overflow=0, out_valid=0, internal operand/counter registers 0. in_ready=1 during and after reset; no handshake is accepted while rst_n is low.
- Reset asserted in EXEC or DONE aborts the operation immediately; no out_valid is produced for it.
- Latency: accept at edge e0; result/flags and out_valid update at edge e0+L; earliest out_valid-high cycle is after e0+L.
- Throughput: out handshake at edge eD returns to IDLE; next accept earliest at eD+1. Minimum issue interval L+2 cycles with out_ready tied high.
- in_ready and out_valid are never high together.
- out_valid held with out_ready low indefinitely: all outputs stable, no new input accepted.
- Changing A/B/op during EXEC/DONE has no effect.

## Test plan
- WIDTH=4, ADD A=4'h7 B=4'h1, out_ready=1 -> after 1 EXEC cycle result=4'h8, carry=0, overflow=1, zero=0; in_ready back high 2 cycles after out_valid edge sequence.
- WIDTH=4, SUB A=4'h3 B=4'h3 then SUB A=4'h2 B=4'h5 -> first result=0, zero=1, carry=0; second result=4'hD, carry=1, overflow=0.
- WIDTH=8, SHL A=8'h81 B=8'h03 -> out_valid exactly 3 cycles after accept, result=8'h08, carry=0; SHR A=8'h81 B=8'h00 -> L=1, result=8'h81, carry=0.
- WIDTH=8, MUL A=8'h10 B=8'h10 -> out_valid 8 cycles after accept, result=8'h00, zero=1, overflow=1; MUL 8'h0F x 8'h03 -> 8'h2D, overflow=0.
- Backpressure: out_ready=0 for 20 cycles in DONE while A/B/op/in_valid toggle -> outputs constant, in_ready=0, no new accept; out_ready=1 -> one handshake, then IDLE.
- Reset mid-MUL (rst_n low 3 cycles into EXEC) -> all outputs 0, state IDLE, out_valid never asserted for aborted op; next ADD after reset completes normally.
